c_splitter_n: RTL and testbench

C_SPLITTER_N -- requirements
Module: c_splitter_n

---
 rtl/c_splitter_n_pkg.sv | 28 ++
 rtl/c_splitter_n_if.sv | 36 +++
 rtl/c_splitter_n_delay_cnt.sv | 34 +++
 rtl/c_splitter_n.sv | 181 ++++++++++++++++++
 tb/tb_c_splitter_n.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/c_splitter_n_pkg.sv
// c_splitter_pkg: the constants and types shared by the c_splitter_n files.
//   state_t         - FSM state encoding (IDLE, ISSUE, WAIT, HOLD, DONE)
//   MODE_COPY       - every lane carries the whole input word
//   MODE_SLICE      - lane k carries slice k of the input word, zero-extended
//   hold_load_value - value loaded into the HOLD countdown for a given delay
package c_splitter_pkg;

    localparam int MODE_COPY  = 0;
    localparam int MODE_SLICE = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The countdown reports done at zero, so a HOLD of D cycles loads D-1.
    function automatic logic [3:0] hold_load_value(input int free_delay);
        if (free_delay > 0) begin
            return 4'(free_delay - 1);
        end else begin
            return 4'd0;
        end
    endfunction

endpackage

// File: rtl/c_splitter_n_if.sv
// c_splitter_n_if: upstream request/data/free handshake plus the N downstream
// branches, bundled for c_splitter_n.
//   i_drive      - one-cycle request pulse from upstream
//   i_data       - DW-bit payload, sampled with i_drive
//   i_mask       - N-bit branch select, sampled with i_drive
//   i_free_next  - N per-branch completion pulses
//   o_drive_next - N per-branch request pulses
//   o_data_next  - N lanes of DW bits, lane k at [k*DW +: DW]
//   o_free       - one-cycle completion pulse to upstream
//   o_busy       - transaction in flight
//   o_err        - sticky protocol-error flag
// modport slave is the splitter side, modport master the upstream/branch side.
interface c_splitter_n_if #(
    parameter int N  = 2,
    parameter int DW = 32
);
    logic              i_drive;
    logic [DW-1:0]     i_data;
    logic [N-1:0]      i_mask;
    logic [N-1:0]      i_free_next;
    logic [N-1:0]      o_drive_next;
    logic [N*DW-1:0]   o_data_next;
    logic              o_free;
    logic              o_busy;
    logic              o_err;

    modport slave (
        input  i_drive, i_data, i_mask, i_free_next,
        output o_drive_next, o_data_next, o_free, o_busy, o_err
    );

    modport master (
        output i_drive, i_data, i_mask, i_free_next,
        input  o_drive_next, o_data_next, o_free, o_busy, o_err
    );
endinterface

// File: rtl/c_splitter_n_delay_cnt.sv
// c_delay_cnt: 4-bit down-counter that times the HOLD state.
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset, clears the count
//   i_load  - load i_value (has priority over i_run)
//   i_value - value to load
//   i_run   - count down by one while nonzero
//   o_done  - count is zero
module c_delay_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_value,
    input  logic       i_run,
    output logic       o_done
);

    logic [3:0] r_cnt;

    // Countdown register: load, decrement toward zero, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_run && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/c_splitter_n.sv
// c_splitter_n: fans one upstream request out to a masked set of N branches,
// waits for every selected branch to report free, waits FREE_DELAY more
// cycles, then returns a single o_free pulse upstream.
//   clk - clock, rising edge
//   rst - asynchronous active-high reset; abandons any transaction
//   bus - c_splitter_n_if slave modport (request, data, mask, frees, status)
// Parameters: N branches (2..8), DW data width, MODE copy/slice,
// FREE_DELAY extra cycles before o_free (0..15).
module c_splitter_n
    import c_splitter_pkg::*;
#(
    parameter int N          = 2,
    parameter int DW         = 32,
    parameter int MODE       = 0,
    parameter int FREE_DELAY = 2
) (
    input  logic            clk,
    input  logic            rst,
    c_splitter_n_if.slave   bus
);

    localparam int         LW        = DW / N;
    localparam logic [3:0] HOLD_LOAD = hold_load_value(FREE_DELAY);

    state_t          r_state;
    logic [DW-1:0]   r_data_q;
    logic [N-1:0]    r_mask_q;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    r_drive_next;
    logic            r_free;
    logic            r_busy;
    logic            r_err;

    logic            w_ready;
    logic            w_collect;
    logic            w_accept;
    logic [N-1:0]    w_allowed;
    logic [N-1:0]    w_pending_nxt;
    logic            w_drive_err;
    logic            w_free_err;
    logic            w_wait_exit;
    logic            w_hold_load;
    logic            w_hold_run;
    logic            w_hold_done;
    logic [N*DW-1:0] w_lanes;

    // A new request is only taken in IDLE or DONE; frees only count in ISSUE or WAIT.
    assign w_ready       = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_collect     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_accept      = w_ready && bus.i_drive;
    assign w_allowed     = w_collect ? r_pending : '0;
    assign w_pending_nxt = r_pending & ~(bus.i_free_next & w_allowed);
    assign w_drive_err   = bus.i_drive && !w_ready;
    assign w_free_err    = |(bus.i_free_next & ~w_allowed);

    // ISSUE never exits directly, so an empty pending set is seen in WAIT.
    assign w_wait_exit   = (r_state == ST_WAIT) && (w_pending_nxt == '0);
    assign w_hold_load   = w_wait_exit && (FREE_DELAY > 0);
    assign w_hold_run    = (r_state == ST_HOLD);

    c_delay_cnt u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hold_load),
        .i_value (HOLD_LOAD),
        .i_run   (w_hold_run),
        .o_done  (w_hold_done)
    );

    // Branch pending set: loaded on accept, cleared bit by bit by accepted frees.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else if (w_accept) begin
            r_pending <= bus.i_mask;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Sticky protocol error: drive while busy, or a free nobody was waiting for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_drive_err || w_free_err) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    // Transaction FSM with its registered outputs and captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_data_q     <= '0;
            r_mask_q     <= '0;
            r_drive_next <= '0;
            r_free       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_free <= 1'b0;
                    if (bus.i_drive) begin
                        r_state      <= ST_ISSUE;
                        r_data_q     <= bus.i_data;
                        r_mask_q     <= bus.i_mask;
                        r_drive_next <= bus.i_mask;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state      <= ST_IDLE;
                        r_drive_next <= '0;
                        r_busy       <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_state      <= ST_WAIT;
                    r_drive_next <= '0;
                    r_busy       <= 1'b1;
                    r_free       <= 1'b0;
                end
                ST_WAIT: begin
                    r_drive_next <= '0;
                    if (w_pending_nxt == '0) begin
                        if (FREE_DELAY > 0) begin
                            r_state <= ST_HOLD;
                            r_busy  <= 1'b1;
                            r_free  <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_free  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_WAIT;
                        r_busy  <= 1'b1;
                        r_free  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    r_drive_next <= '0;
                    if (w_hold_done) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_free  <= 1'b1;
                    end else begin
                        r_state <= ST_HOLD;
                        r_busy  <= 1'b1;
                        r_free  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_drive_next <= '0;
                    r_busy       <= 1'b0;
                    r_free       <= 1'b0;
                end
            endcase
        end
    end

    // Lane formation from the captured word; r_data_q only changes on accept.
    always_comb begin
        w_lanes = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == MODE_COPY) begin
                w_lanes[k*DW +: DW] = r_data_q;
            end else begin
                w_lanes[k*DW +: DW] = DW'(r_data_q[k*LW +: LW]);
            end
        end
    end

    assign bus.o_drive_next = r_drive_next;
    assign bus.o_data_next  = w_lanes;
    assign bus.o_free       = r_free;
    assign bus.o_busy       = r_busy;
    assign bus.o_err        = r_err;

endmodule

// File: tb/tb_c_splitter_n.sv
// Bench for c_splitter_n: two instances (N=2 copy, delay 2 and N=4 slice,
// delay 0) compared every cycle against a transaction-level model, plus
// directed sequences with hand-computed expectations.
module tb_c_splitter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst_v [2];
    logic        drv_v [2];
    logic [31:0] dat_v [2];
    logic [7:0]  msk_v [2];
    logic [7:0]  fre_v [2];

    c_splitter_n_if #(.N(2), .DW(32)) if_a ();
    c_splitter_n_if #(.N(4), .DW(32)) if_b ();

    assign if_a.i_drive     = drv_v[0];
    assign if_a.i_data      = dat_v[0];
    assign if_a.i_mask      = msk_v[0][1:0];
    assign if_a.i_free_next = fre_v[0][1:0];
    assign if_b.i_drive     = drv_v[1];
    assign if_b.i_data      = dat_v[1];
    assign if_b.i_mask      = msk_v[1][3:0];
    assign if_b.i_free_next = fre_v[1][3:0];

    c_splitter_n #(.N(2), .DW(32), .MODE(0), .FREE_DELAY(2)) dut_a (
        .clk(clk), .rst(rst_v[0]), .bus(if_a));
    c_splitter_n #(.N(4), .DW(32), .MODE(1), .FREE_DELAY(0)) dut_b (
        .clk(clk), .rst(rst_v[1]), .bus(if_b));

    // Transaction model: accept edge, request, pending branches, and the edge at
    // which the pending set emptied (exit); o_free comes exit+1+delay.
    int          m_n    [2] = '{2, 4};
    int          m_mode [2] = '{0, 1};
    int          m_dly  [2] = '{2, 0};
    bit          m_active [2] = '{1'b0, 1'b0};
    int          m_d    [2] = '{0, 0};
    logic [7:0]  m_mask [2] = '{8'h00, 8'h00};
    logic [7:0]  m_pend [2] = '{8'h00, 8'h00};
    logic [31:0] m_data [2] = '{32'h0, 32'h0};
    int          m_exit [2] = '{-1, -1};
    logic        m_err  [2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int m_done_c(input int id);
        return (m_exit[id] >= 0) ? (m_exit[id] + 1 + m_dly[id]) : -1;
    endfunction

    function automatic bit m_busy(input int id, input int c);
        int dc;
        dc = m_done_c(id);
        return m_active[id] && !((dc >= 0) && (c >= dc));
    endfunction

    function automatic logic [255:0] exp_lanes(input int id);
        logic [255:0] r;
        logic [31:0]  lane;
        int           w;
        r = '0;
        w = 32 / m_n[id];
        for (int k = 0; k < m_n[id]; k++) begin
            if (m_mode[id] == 1) lane = (m_data[id] >> (k * w)) & (32'hFFFF_FFFF >> (32 - w));
            else                 lane = m_data[id];
            r[k*32 +: 32] = lane;
        end
        return r;
    endfunction

    task automatic model_cycle(input int id, input int c, input logic rst, input logic drive,
                               input logic [31:0] data, input logic [7:0] mask, input logic [7:0] fre,
                               input logic a_busy, input logic [7:0] a_drv, input logic [255:0] a_dat,
                               input logic a_free, input logic a_err);
        logic       e_busy, e_free, e_err, collecting;
        logic [7:0] e_drv;
        string      tag;
        tag = (id == 0) ? "A" : "B";
        if (rst) begin
            m_active[id] = 1'b0; m_pend[id] = 8'h00; m_mask[id] = 8'h00;
            m_data[id] = 32'h0; m_exit[id] = -1; m_err[id] = 1'b0;
            e_busy = 1'b0; e_free = 1'b0; e_drv = 8'h00;
        end else begin
            e_busy = m_busy(id, c);
            e_drv  = (m_active[id] && (c == m_d[id] + 1)) ? m_mask[id] : 8'h00;
            e_free = m_active[id] && (m_done_c(id) == c);
        end
        e_err = m_err[id];
        chk({tag, " busy"}, 256'(a_busy), 256'(e_busy));
        chk({tag, " drive_next"}, 256'(a_drv), 256'(e_drv));
        chk({tag, " free"}, 256'(a_free), 256'(e_free));
        chk({tag, " err"}, 256'(a_err), 256'(e_err));
        chk({tag, " data_next"}, a_dat, exp_lanes(id));
        if (!rst) begin
            collecting = m_active[id] && (m_exit[id] < 0);
            for (int k = 0; k < m_n[id]; k++) begin
                if (fre[k]) begin
                    if (collecting && m_pend[id][k]) m_pend[id][k] = 1'b0;
                    else m_err[id] = 1'b1;
                end
            end
            if (collecting && (c >= m_d[id] + 2) && (m_pend[id] == 8'h00)) m_exit[id] = c;
            if (drive) begin
                if (e_busy) begin
                    m_err[id] = 1'b1;
                end else begin
                    m_active[id] = 1'b1; m_d[id] = c; m_mask[id] = mask;
                    m_pend[id] = mask; m_data[id] = data; m_exit[id] = -1;
                end
            end else if (e_free) begin
                m_active[id] = 1'b0;
            end
        end
    endtask

    // Single compare process: both instances against the model, every cycle.
    initial begin
        forever begin
            @(negedge clk);
            model_cycle(0, cyc, rst_v[0], drv_v[0], dat_v[0], msk_v[0], fre_v[0],
                        if_a.o_busy, 8'(if_a.o_drive_next), 256'(if_a.o_data_next), if_a.o_free, if_a.o_err);
            model_cycle(1, cyc, rst_v[1], drv_v[1], dat_v[1], msk_v[1], fre_v[1],
                        if_b.o_busy, 8'(if_b.o_drive_next), 256'(if_b.o_data_next), if_b.o_free, if_b.o_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int id);
        drv_v[id] = 1'b0; msk_v[id] = 8'h00; fre_v[id] = 8'h00;
    endtask

    task automatic rand_inputs(input int id);
        int n;
        n = m_n[id];
        quiet(id);
        rst_v[id] = ($urandom_range(0, 299) == 0);
        dat_v[id] = $urandom;
        msk_v[id] = 8'($urandom_range(0, (1 << n) - 1));
        if (m_busy(id, cyc)) drv_v[id] = ($urandom_range(0, 49) == 0);
        else                 drv_v[id] = ($urandom_range(0, 2) == 0);
        if (m_active[id] && (m_exit[id] < 0)) begin
            for (int k = 0; k < n; k++)
                if (m_pend[id][k] && ($urandom_range(0, 2) == 0)) fre_v[id][k] = 1'b1;
        end
        if ($urandom_range(0, 59) == 0) fre_v[id][$urandom_range(0, n - 1)] = 1'b1;
    endtask

    initial begin
        for (int id = 0; id < 2; id++) begin
            rst_v[id] = 1'b1; dat_v[id] = 32'h0; quiet(id);
        end
        step(); step();
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        step();
        chk("A reset busy", 256'(if_a.o_busy), 256'(1'b0));
        chk("A reset err", 256'(if_a.o_err), 256'(1'b0));
        chk("A reset data", 256'(if_a.o_data_next), 256'(64'h0));
        chk("B reset drive", 256'(if_b.o_drive_next), 256'(4'h0));

        // Copy mode, delay 2: frees at 3 and 5 give o_free in cycle 8.
        for (int c = 0; c < 11; c++) begin
            drv_v[0] = (c == 0); dat_v[0] = 32'hA5A5_0001; msk_v[0] = 8'h03;
            fre_v[0] = (c == 3) ? 8'h01 : (c == 5) ? 8'h02 : 8'h00;
            if (c == 1) begin
                chk("A37 drive", 256'(if_a.o_drive_next), 256'(2'b11));
                chk("A37 lanes", 256'(if_a.o_data_next), 256'({32'hA5A5_0001, 32'hA5A5_0001}));
            end
            chk("A37 free", 256'(if_a.o_free), 256'(c == 8));
            step();
        end
        quiet(0);
        // Protocol errors mid-transaction; completion still lands at 4+1+2.
        for (int c = 0; c < 10; c++) begin
            drv_v[0] = (c == 0) || (c == 3); msk_v[0] = 8'h03;
            fre_v[0] = (c == 2 || c == 3) ? 8'h01 : (c == 4) ? 8'h02 : 8'h00;
            chk("A40 free", 256'(if_a.o_free), 256'(c == 7));
            chk("A40 err", 256'(if_a.o_err), 256'(c >= 4));
            step();
        end
        quiet(0);
        // Reset in WAIT abandons the request, clears err; next one completes.
        for (int c = 0; c < 12; c++) begin
            drv_v[0] = (c == 0) || (c == 5); msk_v[0] = (c == 5) ? 8'h01 : 8'h03;
            fre_v[0] = (c == 7) ? 8'h01 : 8'h00;
            rst_v[0] = (c == 3);
            if (c == 3) begin
                #1;
                chk("A42 rst busy", 256'(if_a.o_busy), 256'(1'b0));
                chk("A42 rst err", 256'(if_a.o_err), 256'(1'b0));
                chk("A42 rst data", 256'(if_a.o_data_next), 256'(64'h0));
            end
            chk("A42 free", 256'(if_a.o_free), 256'(c == 10));
            step();
        end
        quiet(0);

        // Slice mode, delay 0.
        for (int c = 0; c < 5; c++) begin
            drv_v[1] = (c == 0); dat_v[1] = 32'h4433_2211; msk_v[1] = 8'h05;
            fre_v[1] = (c == 2) ? 8'h05 : 8'h00;
            if (c == 1) begin
                chk("B38 drive", 256'(if_b.o_drive_next), 256'(4'b0101));
                chk("B38 lane0", 256'(if_b.o_data_next[31:0]), 256'(32'h11));
                chk("B38 lane2", 256'(if_b.o_data_next[95:64]), 256'(32'h33));
                chk("B38 lane3", 256'(if_b.o_data_next[127:96]), 256'(32'h44));
            end
            chk("B38 free", 256'(if_b.o_free), 256'(c == 3));
            step();
        end
        // Empty mask: no branch pulse, o_free in cycle 3, no error.
        for (int c = 0; c < 6; c++) begin
            drv_v[1] = (c == 0); msk_v[1] = 8'h00; fre_v[1] = 8'h00;
            chk("B39 drive", 256'(if_b.o_drive_next), 256'(4'h0));
            chk("B39 free", 256'(if_b.o_free), 256'(c == 3));
            chk("B39 err", 256'(if_b.o_err), 256'(1'b0));
            step();
        end
        // Back-to-back: second drive taken in DONE, ISSUE the next cycle.
        for (int c = 0; c < 9; c++) begin
            drv_v[1] = (c == 0) || (c == 3); msk_v[1] = (c == 3) ? 8'h02 : 8'h01;
            fre_v[1] = (c == 2) ? 8'h01 : (c == 5) ? 8'h02 : 8'h00;
            if (c == 4) chk("B41 drive", 256'(if_b.o_drive_next), 256'(4'b0010));
            if (c == 4) chk("B41 busy", 256'(if_b.o_busy), 256'(1'b1));
            chk("B41 free", 256'(if_b.o_free), 256'(c == 3 || c == 6));
            step();
        end
        quiet(1);

        for (int t = 0; t < 4000; t++) begin
            rand_inputs(0);
            rand_inputs(1);
            step();
        end
        for (int id = 0; id < 2; id++) begin
            rst_v[id] = 1'b0; quiet(id);
        end
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
